// File: rtl/nios_system_sysid_ext.sv
// rtl/nios_system_sysid_ext.sv - System-ID slave with scratch, control/status and atomic uptime counter snapshot
module nios_system_sysid_ext #(
    parameter logic [31:0] ID            = 32'h0,
    parameter logic [31:0] TIMESTAMP     = 32'h0,
    parameter logic [31:0] VERSION       = 32'h0,
    parameter int unsigned CLOCK_FREQ    = 50000000,
    parameter int unsigned COUNTER_WIDTH = 64       // legal range 33..64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam int unsigned CW = COUNTER_WIDTH;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_VERSION   = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH   = 3'd5;
    localparam logic [2:0] ADDR_CTRL      = 3'd6;
    localparam logic [2:0] ADDR_CLK_FREQ  = 3'd7;

    localparam logic [31:0] CLOCK_FREQ_W = 32'(CLOCK_FREQ);
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    logic [CW-1:0] counter_q,  counter_d;
    logic [31:0]   shadow_hi_q, shadow_hi_d;
    logic [31:0]   scratch_q,  scratch_d;
    logic          en_q,       en_d;
    logic          ovf_q,      ovf_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          rdv_q,      rdv_d;

    logic          rd_fire;
    logic          wr_ctrl;
    logic          wr_scratch;
    logic          clr;
    logic          wrap;
    logic [63:0]   counter_ext;
    logic [31:0]   rd_mux;

    // Strobe decode; a read colliding with a write is dropped so the write wins
    always_comb begin
        rd_fire     = read & ~write;
        wr_ctrl     = write & (address == ADDR_CTRL);
        wr_scratch  = write & (address == ADDR_SCRATCH);
        clr         = wr_ctrl & writedata[1];
        wrap        = en_q & (counter_q == CNT_MAX) & ~clr;
        counter_ext = 64'(counter_q);
    end

    // Uptime counter: clear beats increment, wrap falls out of the natural rollover
    always_comb begin
        counter_d = counter_q;
        if (clr) begin
            counter_d = '0;
        end else if (en_q) begin
            counter_d = counter_q + CNT_ONE;
        end
    end

    // Control bits: en loads from bit0 on any CTRL write; overflow set dominates its W1C
    always_comb begin
        en_d  = en_q;
        ovf_d = ovf_q;
        if (wr_ctrl) begin
            en_d = writedata[0];
            if (writedata[2]) begin
                ovf_d = 1'b0;
            end
        end
        if (wrap) begin
            ovf_d = 1'b1;
        end
    end

    // Scratch register with per-byte write enables
    always_comb begin
        scratch_d = scratch_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_scratch && byteenable[b]) begin
                scratch_d[8*b +: 8] = writedata[8*b +: 8];
            end
        end
    end

    // Combinational read mux feeding the single output register stage
    always_comb begin
        rd_mux = 32'h0;
        case (address)
            ADDR_ID:        rd_mux = ID;
            ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
            ADDR_VERSION:   rd_mux = VERSION;
            ADDR_UPTIME_LO: rd_mux = counter_ext[31:0];
            ADDR_UPTIME_HI: rd_mux = shadow_hi_q;
            ADDR_SCRATCH:   rd_mux = scratch_q;
            ADDR_CTRL:      rd_mux = {29'h0, ovf_q, 1'b0, en_q};
            ADDR_CLK_FREQ:  rd_mux = CLOCK_FREQ_W;
            default:        rd_mux = 32'h0;
        endcase
    end

    // Read response and snapshot: LO read captures the upper half from the same sample
    always_comb begin
        readdata_d  = readdata_q;
        rdv_d       = rd_fire;
        shadow_hi_d = shadow_hi_q;
        if (rd_fire) begin
            readdata_d = rd_mux;
            if (address == ADDR_UPTIME_LO) begin
                shadow_hi_d = counter_ext[63:32];
            end
        end
    end

    // State registers, asynchronously reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_q   <= '0;
            shadow_hi_q <= 32'h0;
            scratch_q   <= 32'h0;
            en_q        <= 1'b1;
            ovf_q       <= 1'b0;
            readdata_q  <= 32'h0;
            rdv_q       <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            shadow_hi_q <= shadow_hi_d;
            scratch_q   <= scratch_d;
            en_q        <= en_d;
            ovf_q       <= ovf_d;
            readdata_q  <= readdata_d;
            rdv_q       <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule
